// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, FIFO sizing, bit timing and stage state codes.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH  = 8;
    localparam int unsigned CLKS_PER_BIT     = 868;
    localparam int unsigned RX_FIFO_DEPTH    = 16;

    // State codes shared by the receiver and transmitter stages
    localparam logic [2:0] UART_ST_IDLE  = 3'd0;
    localparam logic [2:0] UART_ST_START = 3'd1;
    localparam logic [2:0] UART_ST_DATA  = 3'd2;
    localparam logic [2:0] UART_ST_STOP  = 3'd3;
    localparam logic [2:0] UART_ST_DONE  = 3'd4;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register array: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned DEPTH      = RX_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Next storage contents: only the addressed entry changes on a write
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Storage register; deliberately not reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer with occupancy count and sticky overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned DEPTH      = RX_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_dv,
    input  logic [DATA_WIDTH-1:0]  rx_data,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  overflow_q, overflow_d;

    logic push;
    logic pop;
    logic drop;

    // Status flags come only from the registered count
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign m_valid  = !empty;
    assign count    = count_q;
    assign overflow = overflow_q;

    // Handshake decode, pointer/count/flag next-state
    always_comb begin
        pop  = m_valid && m_ready;
        // A pop frees the slot this cycle, so a full FIFO still accepts the byte
        push = rx_dv && (!full || pop);
        drop = rx_dv && full && !pop;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push && rst_n),
        .wr_addr (wr_ptr_q),
        .wr_data (rx_data),
        .rd_addr (rd_ptr_q),
        .rd_data (m_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo using a byte scoreboard queue.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_dv = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [4:0]    count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          clr_overflow = 1'b0;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int model_count = 0;
    logic model_ovf = 1'b0;
    logic [DW-1:0] sbq[$];

    uart_rx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_dv        (rx_dv),
        .rx_data      (rx_data),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    // Advance one clock: score any handshake that the coming edge completes,
    // update the reference model, then settle 1 time unit past the edge.
    task automatic tick();
        logic do_pop;
        logic do_push;
        logic [DW-1:0] exp;
        do_pop  = (model_count != 0) && m_ready;
        do_push = rx_dv && ((model_count < DEPTH) || do_pop);
        if (!rst_n) begin
            sbq.delete();
            model_count = 0;
            model_ovf   = 1'b0;
        end else begin
            if (do_pop) begin
                exp = sbq.pop_front();
                pops++;
                checks++;
                if (m_data !== exp) begin
                    errors++;
                    $display("FAIL sb_data got %02h expected %02h", m_data, exp);
                end
            end
            if (do_push) sbq.push_back(rx_data);
            if (do_push && !do_pop) model_count++;
            else if (do_pop && !do_push) model_count--;
            if (rx_dv && !do_push) model_ovf = 1'b1;
            else if (clr_overflow) model_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        m_ready = 1'b1;
        for (int i = 0; i < budget && model_count != 0; i++) tick();
        m_ready = 1'b0;
        checks++;
        if (model_count != 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty got count=%0d empty=%0b expected count=0 empty=1", count, empty);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if ({count, m_valid, empty, full, overflow} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got count=%0d v=%0b e=%0b f=%0b o=%0b expected 0 0 1 0 0",
                     count, m_valid, empty, full, overflow);
        end
    endtask

    task automatic test_single();
        rx_dv = 1'b1; rx_data = 8'hA5;
        tick();
        rx_dv = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || count !== 5'd1) begin
            errors++;
            $display("FAIL single_push got v=%0b data=%02h count=%0d expected 1 a5 1", m_valid, m_data, count);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            errors++;
            $display("FAIL single_pop got empty=%0b count=%0d expected 1 0", empty, count);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            rx_dv = 1'b1; rx_data = 8'(i);
            tick();
        end
        rx_dv = 1'b0;
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL fill got full=%0b count=%0d head=%02h expected 1 16 00", full, count, m_data);
        end
        // byte dropped while full
        rx_dv = 1'b1; rx_data = 8'hFF;
        tick();
        rx_dv = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16 || model_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set got ovf=%0b count=%0d expected 1 16", overflow, count);
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clr got %0b expected 0", overflow);
        end
        clr_overflow = 1'b1; rx_dv = 1'b1; rx_data = 8'hFF;
        tick();
        clr_overflow = 1'b0; rx_dv = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set_wins got %0b expected 1", overflow);
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        // push and pop together while full
        rx_dv = 1'b1; rx_data = 8'h55; m_ready = 1'b1;
        tick();
        rx_dv = 1'b0; m_ready = 1'b0;
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || m_data !== 8'h01) begin
            errors++;
            $display("FAIL full_push_pop got count=%0d ovf=%0b head=%02h expected 16 0 01", count, overflow, m_data);
        end
        pops = 0;
        drain(40);
        checks++;
        if (pops != 16) begin
            errors++;
            $display("FAIL drain_len got %0d expected 16", pops);
        end
    endtask

    task automatic test_wrap();
        int pushed = 0;
        for (int cyc = 0; cyc < 2000 && (pushed < 40 || model_count != 0); cyc++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < 40 && model_count < DEPTH - 1 && $urandom_range(0, 3) != 0) begin
                rx_dv = 1'b1; rx_data = 8'($urandom);
                pushed++;
            end else begin
                rx_dv = 1'b0;
            end
            tick();
            rx_dv = 1'b0;
            checks++;
            if (m_valid !== (model_count != 0) || count !== 5'(model_count) || full !== 1'b0) begin
                errors++;
                $display("FAIL wrap_status got v=%0b count=%0d full=%0b expected count=%0d", m_valid, count, full, model_count);
            end
        end
        m_ready = 1'b0;
        checks++;
        if (pushed != 40 || model_count != 0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done got pushed=%0d left=%0d ovf=%0b expected 40 0 0", pushed, model_count, overflow);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            rx_dv = 1'b1; rx_data = 8'h80 + 8'(i);
            tick();
        end
        rx_dv = 1'b0;
        checks++;
        if (count !== 5'd5) begin
            errors++;
            $display("FAIL mid_fill got %0d expected 5", count);
        end
        rst_n = 1'b0; rx_dv = 1'b1; rx_data = 8'h77;
        tick();
        rst_n = 1'b1; rx_dv = 1'b0;
        checks++;
        if (count !== 5'd0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got count=%0d v=%0b expected 0 0", count, m_valid);
        end
        rx_dv = 1'b1; rx_data = 8'h3C;
        tick();
        rx_dv = 1'b0;
        checks++;
        if (m_data !== 8'h3C || count !== 5'd1) begin
            errors++;
            $display("FAIL mid_next got data=%02h count=%0d expected 3c 1", m_data, count);
        end
        drain(10);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
